// File: rtl/arb_ram.sv
// Single-port RAM shared by G_NUM_CH requesters through a round-robin arbiter.
// Define ARB_RAM_INIT_EN to add the post-reset clear sweep (S_INIT); without it the RAM starts in S_RUN.
module arb_ram #(
  parameter int G_ADDR_WIDTH = 4,
  parameter int G_DATA_WIDTH = 8,
  parameter int G_NUM_CH     = 2,
  localparam int CHW = (G_NUM_CH > 1) ? $clog2(G_NUM_CH) : 1
) (
  input  logic                             CLOCK,
  input  logic                             RST,
  input  logic [G_NUM_CH-1:0]              REQ,
  input  logic [G_NUM_CH-1:0]              WE,
  input  logic [G_NUM_CH*G_ADDR_WIDTH-1:0] ADDR,
  input  logic [G_NUM_CH*G_DATA_WIDTH-1:0] WDATA,
  output logic [G_NUM_CH-1:0]              GNT,
  output logic                             RD_VALID,
  output logic [CHW-1:0]                   RD_CH,
  output logic [G_DATA_WIDTH-1:0]          RD_DATA,
  output logic                             INIT_BUSY
);

  localparam int DEPTH = 2**G_ADDR_WIDTH;

  logic [G_DATA_WIDTH-1:0] mem [DEPTH];
  logic [CHW-1:0]          ptr;
  logic [CHW-1:0]          sel;
  logic [CHW-1:0]          cand;
  logic                    found;
  logic                    run;
  logic                    we_sel;
  logic [G_ADDR_WIDTH-1:0] addr_sel;
  logic [G_DATA_WIDTH-1:0] wdata_sel;

`ifdef ARB_RAM_INIT_EN
  typedef enum logic {S_INIT, S_RUN} state_t;
  state_t                  state;
  logic [G_ADDR_WIDTH-1:0] cnt;
  logic                    sweep;

  always_ff @(posedge CLOCK or posedge RST) begin : init_fsm
    if (RST) begin
      state <= S_INIT;
      cnt   <= '0;
    end else begin
      case (state)
        S_INIT: begin
          cnt <= cnt + 1'b1;
          if (&cnt) state <= S_RUN;
        end
        default: ;
      endcase
    end
  end

  assign INIT_BUSY = (state == S_INIT);
  assign sweep     = INIT_BUSY && !RST;
  assign run       = !INIT_BUSY && !RST;
`else
  assign INIT_BUSY = 1'b0;
  assign run       = !RST;
`endif

  // Search starts one past the last granted channel and wraps.
  always_comb begin : arbiter
    GNT   = '0;
    found = 1'b0;
    sel   = '0;
    cand  = (ptr == CHW'(G_NUM_CH-1)) ? '0 : ptr + 1'b1;
    for (int k = 0; k < G_NUM_CH; k++) begin
      if (run && !found && REQ[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
      cand = (cand == CHW'(G_NUM_CH-1)) ? '0 : cand + 1'b1;
    end
    if (found) GNT[sel] = 1'b1;
  end

  always_comb begin : chan_mux
    addr_sel  = '0;
    wdata_sel = '0;
    we_sel    = WE[sel];
    for (int i = 0; i < G_NUM_CH; i++) begin
      if (sel == CHW'(i)) begin
        addr_sel  = ADDR[i*G_ADDR_WIDTH +: G_ADDR_WIDTH];
        wdata_sel = WDATA[i*G_DATA_WIDTH +: G_DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge CLOCK or posedge RST) begin : read_port
    if (RST) begin
      ptr      <= CHW'(G_NUM_CH-1);
      RD_VALID <= 1'b0;
      RD_CH    <= '0;
      RD_DATA  <= '0;
    end else begin
      RD_VALID <= found && !we_sel;
      if (found) ptr <= sel;
      if (found && !we_sel) begin
        RD_CH   <= sel;
        RD_DATA <= mem[addr_sel];
      end
    end
  end

  // Storage is cleared by the sweep rather than by reset.
  always_ff @(posedge CLOCK) begin : storage
`ifdef ARB_RAM_INIT_EN
    if (sweep) mem[cnt] <= '0;
    else if (found && we_sel) mem[addr_sel] <= wdata_sel;
`else
    if (found && we_sel) mem[addr_sel] <= wdata_sel;
`endif
  end

endmodule

// File: tb/tb_arb_ram.sv
// Bench for arb_ram: 2-channel instance against a reference model, plus a 4-channel grant-order check.
module tb_arb_ram;

`ifdef ARB_RAM_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic        CLOCK = 1'b0;
  logic        RST   = 1'b1;
  logic [1:0]  REQ = '0, WE = '0;
  logic [7:0]  ADDR = '0;
  logic [15:0] WDATA = '0;
  logic [1:0]  GNT;
  logic        RD_VALID, RD_CH, INIT_BUSY;
  logic [7:0]  RD_DATA;

  logic [3:0]  req4 = '0, we4 = '0;
  logic [15:0] addr4 = '0;
  logic [31:0] wdata4 = '0;
  logic [3:0]  gnt4;
  logic        rd_valid4, init_busy4;
  logic [1:0]  rd_ch4;
  logic [7:0]  rd_data4;

  arb_ram #(.G_ADDR_WIDTH(4), .G_DATA_WIDTH(8), .G_NUM_CH(2)) dut (
    .CLOCK(CLOCK), .RST(RST), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
    .GNT(GNT), .RD_VALID(RD_VALID), .RD_CH(RD_CH), .RD_DATA(RD_DATA), .INIT_BUSY(INIT_BUSY));

  arb_ram #(.G_ADDR_WIDTH(4), .G_DATA_WIDTH(8), .G_NUM_CH(4)) dut4 (
    .CLOCK(CLOCK), .RST(RST), .REQ(req4), .WE(we4), .ADDR(addr4), .WDATA(wdata4),
    .GNT(gnt4), .RD_VALID(rd_valid4), .RD_CH(rd_ch4), .RD_DATA(rd_data4), .INIT_BUSY(init_busy4));

  always #5 CLOCK = ~CLOCK;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0] mem_m [16];
  bit         known [16];
  int         last_m;
  bit         ev_m;
  int         ech_m;
  logic [7:0] ed_m;
  bit         dknown_m;
  logic [1:0] sampled_gnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int model_grant(input logic [1:0] req);
    for (int k = 1; k <= 2; k++) begin
      if (req[(last_m + k) % 2]) return (last_m + k) % 2;
    end
    return -1;
  endfunction

  task automatic model_reset();
    last_m   = 1;
    ev_m     = 0;
    ech_m    = 0;
    ed_m     = 8'h00;
    dknown_m = 1;
    if (INIT_EN) begin
      for (int i = 0; i < 16; i++) begin
        mem_m[i] = 8'h00;
        known[i] = 1;
      end
    end
  endtask

  task automatic wait_init();
    int n = 0;
    while (INIT_BUSY === 1'b1 && n < 100) begin
      chk("gnt_during_init", {30'd0, GNT}, 0);
      chk("gnt4_during_init", {28'd0, gnt4}, 0);
      chk("rdv_during_init", {31'd0, RD_VALID}, 0);
      @(negedge CLOCK);
      n++;
    end
    chk("init_len", n, INIT_EN ? 16 : 0);
    chk("init_busy_low", {31'd0, INIT_BUSY}, 0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    chk("rst_gnt", {30'd0, GNT}, 0);
    chk("rst_rd_valid", {31'd0, RD_VALID}, 0);
    chk("rst_rd_ch", {31'd0, RD_CH}, 0);
    chk("rst_rd_data", {24'd0, RD_DATA}, 0);
    chk("rst_init_busy", {31'd0, INIT_BUSY}, {31'd0, INIT_EN});
    chk("rst_gnt4", {28'd0, gnt4}, 0);
    RST = 1'b0;
    model_reset();
    wait_init();
  endtask

  task automatic step(input logic [1:0] req, input logic [1:0] we, input logic [7:0] a, input logic [15:0] wd);
    int g;
    int ad;
    REQ = req; WE = we; ADDR = a; WDATA = wd;
    #1;
    g = model_grant(req);
    chk("gnt", {30'd0, GNT}, (g < 0) ? 0 : (1 << g));
    sampled_gnt = GNT;
    @(posedge CLOCK);
    ev_m = 0;
    if (g >= 0) begin
      last_m = g;
      ad = int'(a[g*4 +: 4]);
      if (we[g]) begin
        mem_m[ad] = wd[g*8 +: 8];
        known[ad] = 1;
      end else begin
        ev_m = 1; ech_m = g; ed_m = mem_m[ad]; dknown_m = known[ad];
      end
    end
    @(negedge CLOCK);
    chk("rd_valid", {31'd0, RD_VALID}, {31'd0, ev_m});
    chk("rd_ch", {31'd0, RD_CH}, ech_m);
    if (dknown_m) chk("rd_data", {24'd0, RD_DATA}, {24'd0, ed_m});
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [7:0]  addr;
    logic [15:0] wd;
    logic [1:0]  gnt;
    logic        v;
    logic        ch;
    logic [7:0]  d;
  } vec_t;

  vec_t vt [11];
  logic [3:0] exp4 [10];

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_m[i] = 'x;
      known[i] = 0;
    end
    // Ch0 write/ch1 readback, then six alternating reads, idle, and a ch1 write read back by ch0
    vt[0]  = '{2'b01, 2'b01, 8'h03, 16'h00A5, 2'b01, 1'b0, 1'b0, 8'h00};
    vt[1]  = '{2'b10, 2'b00, 8'h30, 16'h0000, 2'b10, 1'b1, 1'b1, 8'hA5};
    vt[2]  = '{2'b11, 2'b00, 8'h43, 16'h0000, 2'b01, 1'b1, 1'b0, 8'hA5};
    vt[3]  = '{2'b11, 2'b00, 8'h43, 16'h0000, 2'b10, 1'b1, 1'b1, 8'h00};
    vt[4]  = '{2'b11, 2'b00, 8'h43, 16'h0000, 2'b01, 1'b1, 1'b0, 8'hA5};
    vt[5]  = '{2'b11, 2'b00, 8'h43, 16'h0000, 2'b10, 1'b1, 1'b1, 8'h00};
    vt[6]  = '{2'b11, 2'b00, 8'h43, 16'h0000, 2'b01, 1'b1, 1'b0, 8'hA5};
    vt[7]  = '{2'b11, 2'b00, 8'h43, 16'h0000, 2'b10, 1'b1, 1'b1, 8'h00};
    vt[8]  = '{2'b00, 2'b00, 8'h00, 16'h0000, 2'b00, 1'b0, 1'b1, 8'h00};
    vt[9]  = '{2'b10, 2'b10, 8'h40, 16'h3C00, 2'b10, 1'b0, 1'b1, 8'h00};
    vt[10] = '{2'b01, 2'b00, 8'h04, 16'h0000, 2'b01, 1'b1, 1'b0, 8'h3C};
    exp4 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};

    // Requests held through reset and init must not be granted early
    REQ = 2'b11; WE = 2'b00;
    do_reset();
    for (int i = 0; i < 16; i++) step(2'b11, 2'b00, {i[3:0], i[3:0]}, 16'h0);
    for (int i = 0; i < 16; i++) step(2'b01, 2'b01, {4'h0, i[3:0]}, 16'h0);

    for (int i = 0; i < 11; i++) begin
      step(vt[i].req, vt[i].we, vt[i].addr, vt[i].wd);
      chk($sformatf("vec%0d_gnt", i), {30'd0, sampled_gnt}, {30'd0, vt[i].gnt});
      chk($sformatf("vec%0d_valid", i), {31'd0, RD_VALID}, {31'd0, vt[i].v});
      if (vt[i].v) begin
        chk($sformatf("vec%0d_ch", i), {31'd0, RD_CH}, {31'd0, vt[i].ch});
        chk($sformatf("vec%0d_data", i), {24'd0, RD_DATA}, {24'd0, vt[i].d});
      end
    end
    REQ = 2'b00;

    // Four channels: all request, then channel 2 drops out
    for (int i = 0; i < 10; i++) begin
      req4 = (i < 4) ? 4'b1111 : 4'b1011;
      #1;
      chk($sformatf("gnt4_seq%0d", i), {28'd0, gnt4}, {28'd0, exp4[i]});
      @(negedge CLOCK);
    end
    req4 = 4'b0000;

    for (int i = 0; i < 400; i++)
      step(2'($urandom), 2'($urandom), 8'($urandom), 16'($urandom));

    // Reset lands right after a read grant: the read must vanish
    step(2'b01, 2'b01, 8'h03, 16'h00A5);
    REQ = 2'b01; WE = 2'b00; ADDR = 8'h03;
    @(posedge CLOCK);
    #1 RST = 1'b1;
    #1;
    chk("pend_rd_valid", {31'd0, RD_VALID}, 0);
    chk("pend_rd_data", {24'd0, RD_DATA}, 0);
    chk("pend_rd_ch", {31'd0, RD_CH}, 0);
    chk("pend_gnt", {30'd0, GNT}, 0);
    REQ = 2'b00;
    do_reset();
    step(2'b10, 2'b00, 8'h30, 16'h0);

    // Reset pulsed seven cycles into the sweep, with a read request held
    REQ = 2'b01; WE = 2'b00; ADDR = 8'h03;
    RST = 1'b1;
    @(posedge CLOCK);
    @(negedge CLOCK);
    RST = 1'b0;
    repeat (7) begin
      @(negedge CLOCK);
      chk("sweep7_gnt", {30'd0, GNT}, INIT_EN ? 0 : 1);
    end
    RST = 1'b1;
    #1;
    chk("sweep7_rd_valid", {31'd0, RD_VALID}, 0);
    chk("sweep7_gnt_rst", {30'd0, GNT}, 0);
    chk("sweep7_busy", {31'd0, INIT_BUSY}, {31'd0, INIT_EN});
    do_reset();
    step(2'b01, 2'b00, 8'h03, 16'h0);
    step(2'b11, 2'b00, 8'h33, 16'h0);
    step(2'b00, 2'b00, 8'h00, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
